// File: rtl/d5m_pattern_gen.sv
// D5M sensor-output emulator: registered FVAL/LVAL/12-bit Bayer RAW frames from a synthetic pattern.
// Optional macro PATGEN_FRAME_STAMP_EN overlays the frame count on pixels 0/1 of line 0.
module d5m_pattern_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 960,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned F_PORCH  = 32,
  parameter int unsigned V_BLANK  = 4000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSTART,
  input  logic        iEND,
  input  logic [1:0]  iPAT,
  input  logic [11:0] iSOLID,
  output logic [11:0] oDATA,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [31:0] oFrame_Cont
);

  typedef enum logic [2:0] {IDLE, FRONT, LINE, HBLANK, VBLANK} state_t;

  state_t      state, state_n;
  logic [15:0] x, x_n, y, y_n, cnt, cnt_n;
  logic        frame_done;
  logic        stop_q;
  logic [1:0]  pat_q;
  logic [11:0] solid_q;
  logic [31:0] bar;
  logic [2:0]  idx;
  logic        comp_on;
  logic [11:0] pix;

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    cnt_n      = cnt;
    frame_done = 1'b0;
    unique case (state)
      IDLE:
        if (iSTART && !iEND) begin
          state_n = FRONT;
          cnt_n   = '0;
        end
      FRONT:
        if (cnt == 16'(F_PORCH - 1)) begin
          state_n = LINE;
          x_n     = '0;
          y_n     = '0;
        end else cnt_n = cnt + 16'd1;
      LINE:
        if (x == 16'(H_ACTIVE - 1)) begin
          cnt_n = '0;
          if (y == 16'(V_ACTIVE - 1)) begin
            state_n    = VBLANK;
            frame_done = 1'b1;
          end else state_n = HBLANK;
        end else x_n = x + 16'd1;
      HBLANK:
        if (cnt == 16'(H_BLANK - 1)) begin
          state_n = LINE;
          x_n     = '0;
          y_n     = y + 16'd1;
        end else cnt_n = cnt + 16'd1;
      VBLANK:
        if (cnt == 16'(V_BLANK - 1)) begin
          state_n = (stop_q || iEND) ? IDLE : FRONT;
          cnt_n   = '0;
        end else cnt_n = cnt + 16'd1;
      default: state_n = IDLE;
    endcase
  end

  // Pixel is computed from the next-cycle coordinates so it lines up with the registered LVAL.
  always_comb begin
    bar = (32'(x_n) * 32'd8) / H_ACTIVE;
    idx = 3'(32'd7 - bar);
    unique case ({y_n[0], x_n[0]})
      2'b00:   comp_on = idx[1];
      2'b01:   comp_on = idx[2];
      2'b10:   comp_on = idx[0];
      default: comp_on = idx[1];
    endcase
    unique case (pat_q)
      2'd0:    pix = x_n[11:0] + y_n[11:0] + oFrame_Cont[11:0];
      2'd1:    pix = comp_on ? '1 : '0;
      2'd2:    pix = solid_q;
      default: pix = (x_n[4] ^ y_n[4]) ? '1 : '0;
    endcase
`ifdef PATGEN_FRAME_STAMP_EN
    if (y_n == 16'd0 && x_n == 16'd0) pix = {4'hA, oFrame_Cont[7:0]};
    else if (y_n == 16'd0 && x_n == 16'd1) pix = oFrame_Cont[19:8];
`endif
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      cnt         <= '0;
      stop_q      <= 1'b0;
      pat_q       <= '0;
      solid_q     <= '0;
      oDATA       <= '0;
      oFVAL       <= 1'b0;
      oLVAL       <= 1'b0;
      oFrame_Cont <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      cnt   <= cnt_n;
      if (state == IDLE) stop_q <= 1'b0;
      else if (iEND)     stop_q <= 1'b1;
      if (state_n == FRONT && state != FRONT) begin
        pat_q   <= iPAT;
        solid_q <= iSOLID;
      end
      oFVAL <= (state_n == FRONT) || (state_n == LINE) || (state_n == HBLANK);
      oLVAL <= (state_n == LINE);
      oDATA <= (state_n == LINE) ? pix : '0;
      if (frame_done) oFrame_Cont <= oFrame_Cont + 32'd1;
    end
  end

endmodule

// File: tb/tb_d5m_pattern_gen.sv
// Directed bench for d5m_pattern_gen with small frame geometry; expectations follow the
// PATGEN_FRAME_STAMP_EN setting of the build.
module tb_d5m_pattern_gen;

  localparam int unsigned H_ACTIVE = 8;
  localparam int unsigned V_ACTIVE = 4;
  localparam int unsigned H_BLANK  = 2;
  localparam int unsigned F_PORCH  = 3;
  localparam int unsigned V_BLANK  = 5;
`ifdef PATGEN_FRAME_STAMP_EN
  localparam bit STAMP = 1'b1;
`else
  localparam bit STAMP = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_N, iSTART, iEND;
  logic [1:0]  iPAT;
  logic [11:0] iSOLID;
  logic [11:0] oDATA;
  logic        oFVAL, oLVAL;
  logic [31:0] oFrame_Cont;

  d5m_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .F_PORCH(F_PORCH), .V_BLANK(V_BLANK)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iEND(iEND),
    .iPAT(iPAT), .iSOLID(iSOLID), .oDATA(oDATA), .oFVAL(oFVAL),
    .oLVAL(oLVAL), .oFrame_Cont(oFrame_Cont)
  );

  always #5 iCLK = ~iCLK;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [11:0] pix [4][8];
  int unsigned front_len, line_cnt, tail_gap, bad_len, bad_gap, bad_low, timeouts;
  int unsigned high_cnt;

  // Bar pattern rows for H_ACTIVE=8 (bar index equals x).
  logic [11:0] bars_even [8] = '{12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000};
  logic [11:0] bars_odd  [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000};

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] expx(input int unsigned yy, input int unsigned xx,
                                       input logic [31:0] fc, input logic [11:0] base);
    if (STAMP && yy == 0 && xx == 0) return {4'hA, fc[7:0]};
    if (STAMP && yy == 0 && xx == 1) return fc[19:8];
    return base;
  endfunction

  // Follows one frame from FVAL rise to FVAL fall, recording pixels and timing faults.
  task automatic capture_frame(input int unsigned end_line);
    int unsigned guard, xi, gap;
    guard = 0; xi = 0; gap = 0;
    front_len = 0; line_cnt = 0; bad_len = 0; bad_gap = 0; bad_low = 0; tail_gap = 0;
    while (!oFVAL && guard < 100) begin step(); guard++; end
    if (!oFVAL) begin timeouts++; return; end
    while (oFVAL && guard < 300) begin
      iEND = (line_cnt == end_line && xi == 4);
      if (oLVAL) begin
        if (xi == 0 && line_cnt > 0 && gap != H_BLANK) bad_gap++;
        if (line_cnt < 4 && xi < 8) pix[line_cnt][xi] = oDATA;
        xi++;
      end else begin
        if (oDATA !== 12'h000) bad_low++;
        if (xi != 0) begin
          if (xi != H_ACTIVE) bad_len++;
          line_cnt++; xi = 0; gap = 0;
        end
        if (line_cnt == 0) front_len++; else gap++;
      end
      step(); guard++;
    end
    iEND = 1'b0;
    if (oFVAL) timeouts++;
    if (xi != 0) begin
      if (xi != H_ACTIVE) bad_len++;
      line_cnt++;
    end else tail_gap = gap;
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_front"}, front_len, F_PORCH);
    chk({tag, "_lines"}, line_cnt, V_ACTIVE);
    chk({tag, "_linelen"}, bad_len, 0);
    chk({tag, "_hblank"}, bad_gap, 0);
    chk({tag, "_tail"}, tail_gap, 0);
    chk({tag, "_lowdata"}, bad_low, 0);
    chk({tag, "_lval_out"}, {31'd0, oLVAL}, 0);
  endtask

  initial begin
    timeouts = 0;
    iRST_N = 1'b0; iSTART = 1'b0; iEND = 1'b0; iPAT = 2'd0; iSOLID = 12'h000;
    step(); step(); step();
    chk("rst_fval", {31'd0, oFVAL}, 0);
    chk("rst_lval", {31'd0, oLVAL}, 0);
    chk("rst_data", {20'd0, oDATA}, 0);
    chk("rst_cont", oFrame_Cont, 0);
    iRST_N = 1'b1;
    step();

    // Solid frame, single-cycle start
    iSTART = 1'b1; iPAT = 2'd2; iSOLID = 12'h5A5;
    step();
    iSTART = 1'b0; iSOLID = 12'h000; iPAT = 2'd0;
    chk("fval_rise", {31'd0, oFVAL}, 1);
    chk("lval_front", {31'd0, oLVAL}, 0);
    capture_frame(99);
    frame_checks("solid");
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++)
        chk($sformatf("solid_y%0d_x%0d", yy, xx), {20'd0, pix[yy][xx]},
            {20'd0, expx(yy, xx, 32'd0, 12'h5A5)});
    chk("solid_cont", oFrame_Cont, 1);

    iRST_N = 1'b0;
    step();
    iRST_N = 1'b1;
    chk("rst2_cont", oFrame_Cont, 0);
    chk("rst2_fval", {31'd0, oFVAL}, 0);

    // Ramp frames 0 and 1
    iPAT = 2'd0; iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    capture_frame(99);
    frame_checks("ramp0");
    for (int xx = 0; xx < 8; xx++) begin
      chk($sformatf("ramp0_y0_x%0d", xx), {20'd0, pix[0][xx]}, {20'd0, expx(0, xx, 32'd0, 12'(xx))});
      chk($sformatf("ramp0_y1_x%0d", xx), {20'd0, pix[1][xx]}, {20'd0, 12'(xx + 1)});
      chk($sformatf("ramp0_y3_x%0d", xx), {20'd0, pix[3][xx]}, {20'd0, 12'(xx + 3)});
    end
    capture_frame(99);
    frame_checks("ramp1");
    for (int xx = 0; xx < 8; xx++)
      chk($sformatf("ramp1_y0_x%0d", xx), {20'd0, pix[0][xx]}, {20'd0, expx(0, xx, 32'd1, 12'(xx + 1))});
    chk("ramp1_cont", oFrame_Cont, 2);

    // Colour bars; stop requested mid-line 1, frame must still complete
    iPAT = 2'd1;
    capture_frame(1);
    frame_checks("bars");
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++)
        chk($sformatf("bars_y%0d_x%0d", yy, xx), {20'd0, pix[yy][xx]},
            {20'd0, expx(yy, xx, 32'd2, (yy % 2 == 0) ? bars_even[xx] : bars_odd[xx])});
    chk("bars_cont", oFrame_Cont, 3);
    high_cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (oFVAL) high_cnt++; end
    chk("stop_idle", high_cnt, 0);

    // Reset mid-line
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    for (int i = 0; i < 20 && !oLVAL; i++) step();
    chk("pre_rst_lval", {31'd0, oLVAL}, 1);
    step(); step();
    iRST_N = 1'b0;
    step();
    iRST_N = 1'b1;
    chk("midrst_fval", {31'd0, oFVAL}, 0);
    chk("midrst_lval", {31'd0, oLVAL}, 0);
    chk("midrst_data", {20'd0, oDATA}, 0);
    chk("midrst_cont", oFrame_Cont, 0);
    iSTART = 1'b1; iEND = 1'b1;
    high_cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (oFVAL) high_cnt++; end
    chk("start_end_idle", high_cnt, 0);
    iSTART = 1'b0; iEND = 1'b0;
    step();

    // Checker frames 0..5; frame 5 carries count 5 in its stamp
    iPAT = 2'd3; iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    for (int f = 0; f < 5; f++) capture_frame(99);
    chk("chk_cont5", oFrame_Cont, 5);
    capture_frame(2);
    frame_checks("chk5");
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++)
        chk($sformatf("chk5_y%0d_x%0d", yy, xx), {20'd0, pix[yy][xx]},
            {20'd0, expx(yy, xx, 32'd5, 12'h000)});
    chk("chk_cont6", oFrame_Cont, 6);
    high_cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (oFVAL) high_cnt++; end
    chk("chk_stop_idle", high_cnt, 0);

    chk("timeouts", timeouts, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
